// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU types for the PC redirect path.
// Holds the PC-select encoding seen by the PC register, the word type,
// and the two target helpers used by the redirect target calculator.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    PC_SEQ = 2'd0,
    PC_BR  = 2'd1,
    PC_J   = 2'd2,
    PC_JR  = 2'd3
  } pcselect_t;

  // Branch target: PC+4 plus the sign-extended word offset, wrapping mod 2^32.
  function automatic word_t br_target(input word_t npc, input logic [15:0] imm);
    word_t w_off;
    w_off = {{14{imm[15]}}, imm, 2'b00};
    return npc + w_off;
  endfunction

  // Jump target: region bits of PC+4 with the instruction index as word address.
  function automatic word_t j_target(input word_t npc, input logic [25:0] idx);
    return {npc[31:28], idx, 2'b00};
  endfunction

endpackage

// File: rtl/pc_target_calc.sv
// pc_target_calc: combinational redirect decode for the EX stage.
// Decides whether the EX instruction redirects the PC, which source wins
// (JR over J over taken BR) and what the target address is. JR targets are
// forwarded as-is, including any misaligned low bits.
module pc_target_calc
  import cpu_types_pkg::*;
(
  input  logic        i_ex_valid,
  input  logic        i_ex_br,
  input  logic        i_ex_br_taken,
  input  logic        i_ex_j,
  input  logic        i_ex_jr,
  input  logic [31:0] i_ex_npc,
  input  logic [15:0] i_ex_imm,
  input  logic [25:0] i_ex_jidx,
  input  logic [31:0] i_ex_rs,
  output logic        o_accept,
  output logic        o_is_br,
  output pcselect_t   o_sel,
  output logic [31:0] o_target
);

  logic w_br_hit;

  assign w_br_hit = i_ex_br & i_ex_br_taken;

  // Priority select of redirect source and target.
  always_comb begin
    o_accept = 1'b0;
    o_is_br  = 1'b0;
    o_sel    = PC_SEQ;
    o_target = '0;
    if (i_ex_valid) begin
      if (i_ex_jr) begin
        o_accept = 1'b1;
        o_sel    = PC_JR;
        o_target = i_ex_rs;
      end else if (i_ex_j) begin
        o_accept = 1'b1;
        o_sel    = PC_J;
        o_target = j_target(i_ex_npc, i_ex_jidx);
      end else if (w_br_hit) begin
        o_accept = 1'b1;
        o_is_br  = 1'b1;
        o_sel    = PC_BR;
        o_target = br_target(i_ex_npc, i_ex_imm);
      end
    end
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: issues PC redirects from EX and holds each one until
// the fetch handshake (ihit) consumes it. Flush pulses for one cycle when a
// redirect is accepted; busy stalls EX while a redirect is outstanding.
// A HALT freezes the PC permanently (until reset), after any outstanding
// redirect has been consumed.
//
// Optional build macro: PC_REDIRECT_STATS_EN adds saturating redirect_cnt and
// br_taken_cnt outputs (STAT_W bits each).
//
//   state  | meaning
//   RUN    | idle; watching EX for redirects or HALT
//   HOLD   | redirect driven and held until ihit consumes it
//   HALTED | PC frozen; only reset leaves this state
module pc_redirect_ctrl
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
`ifdef PC_REDIRECT_STATS_EN
  ,
  parameter int STAT_W = 16
`endif
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic        ex_valid,
  input  logic        ex_br,
  input  logic        ex_br_taken,
  input  logic        ex_j,
  input  logic        ex_jr,
  input  logic [31:0] ex_npc,
  input  logic [15:0] ex_imm,
  input  logic [25:0] ex_jidx,
  input  logic [31:0] ex_rs,
  input  logic        halt_req,
  output pcselect_t   pc_select,
  output logic [31:0] jump_data,
  output logic [31:0] init,
  output logic        pc_halt,
  output logic        flush,
  output logic        busy
`ifdef PC_REDIRECT_STATS_EN
  ,
  output logic [STAT_W-1:0] redirect_cnt,
  output logic [STAT_W-1:0] br_taken_cnt
`endif
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [1:0]  r_state;
  pcselect_t   r_pc_select;
  logic [31:0] r_jump_data;
  logic        r_pc_halt;
  logic        r_flush;
  logic        r_busy;
  logic        r_halt_pend;

  logic        w_accept;
  logic        w_is_br;
  pcselect_t   w_sel;
  logic [31:0] w_target;

  pc_target_calc u_target (
    .i_ex_valid    (ex_valid),
    .i_ex_br       (ex_br),
    .i_ex_br_taken (ex_br_taken),
    .i_ex_j        (ex_j),
    .i_ex_jr       (ex_jr),
    .i_ex_npc      (ex_npc),
    .i_ex_imm      (ex_imm),
    .i_ex_jidx     (ex_jidx),
    .i_ex_rs       (ex_rs),
    .o_accept      (w_accept),
    .o_is_br       (w_is_br),
    .o_sel         (w_sel),
    .o_target      (w_target)
  );

  // Redirect / halt sequencing and all registered PC-interface outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_RUN;
      r_pc_select <= PC_SEQ;
      r_jump_data <= '0;
      r_pc_halt   <= 1'b0;
      r_flush     <= 1'b0;
      r_busy      <= 1'b0;
      r_halt_pend <= 1'b0;
    end else begin
      r_flush <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (w_accept) begin
            // A HALT arriving alongside a redirect waits for the redirect.
            r_pc_select <= w_sel;
            r_jump_data <= w_target;
            r_flush     <= 1'b1;
            r_busy      <= 1'b1;
            r_halt_pend <= halt_req;
            r_state     <= ST_HOLD;
          end else if (halt_req) begin
            r_pc_halt <= 1'b1;
            r_state   <= ST_HALTED;
          end
        end
        ST_HOLD: begin
          if (halt_req) begin
            r_halt_pend <= 1'b1;
          end
          if (ihit) begin
            r_pc_select <= PC_SEQ;
            r_busy      <= 1'b0;
            if (r_halt_pend || halt_req) begin
              r_pc_halt   <= 1'b1;
              r_halt_pend <= 1'b0;
              r_state     <= ST_HALTED;
            end else begin
              r_state <= ST_RUN;
            end
          end
        end
        ST_HALTED: begin
          r_pc_halt   <= 1'b1;
          r_pc_select <= PC_SEQ;
          r_busy      <= 1'b0;
        end
        default: begin
          r_state     <= ST_RUN;
          r_pc_select <= PC_SEQ;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef PC_REDIRECT_STATS_EN
  logic [STAT_W-1:0] r_redirect_cnt;
  logic [STAT_W-1:0] r_br_taken_cnt;

  // Saturating counts of redirects accepted in RUN (HALTED never accepts).
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_redirect_cnt <= '0;
      r_br_taken_cnt <= '0;
    end else if ((r_state == ST_RUN) && w_accept) begin
      if (!(&r_redirect_cnt)) begin
        r_redirect_cnt <= r_redirect_cnt + 1'b1;
      end
      if (w_is_br && !(&r_br_taken_cnt)) begin
        r_br_taken_cnt <= r_br_taken_cnt + 1'b1;
      end
    end
  end

  assign redirect_cnt = r_redirect_cnt;
  assign br_taken_cnt = r_br_taken_cnt;
`endif

  assign pc_select = r_pc_select;
  assign jump_data = r_jump_data;
  assign init      = PC_RESET;
  assign pc_halt   = r_pc_halt;
  assign flush     = r_flush;
  assign busy      = r_busy;

endmodule
